// File: rtl/mac_seq.sv
// Matrix-vector sequencer: streams M*x operands row by row into an external MAC
// and writes each accumulated row result once the MAC pipeline has drained.
module mac_seq #(
    parameter int unsigned DW   = 32,
    parameter int unsigned NMAX = 8,
    parameter int unsigned LAT  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    n,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [5:0]    m_addr,
    output logic [2:0]    x_addr,
    input  logic [DW-1:0] m_data,
    input  logic [DW-1:0] x_data,
    output logic          mac_new,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    input  logic [DW-1:0] mac_p,
    output logic          y_we,
    output logic [2:0]    y_addr,
    output logic [DW-1:0] y_data
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StWrite} state_e;

    state_e        state_q;
    logic [3:0]    n_q;
    logic [2:0]    row_q;
    logic [2:0]    col_q;
    logic [CW-1:0] drain_q;
    logic          dvalid_q;
    logic          first_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [5:0]    m_addr_q;
    logic [2:0]    x_addr_q;
    logic          y_we_q;
    logic [2:0]    y_addr_q;

    logic       n_legal;
    logic       last_col;
    logic       last_row;
    logic [5:0] row_base;
    logic [5:0] next_row_base;

    always_comb begin
        n_legal       = (n != 4'd0) && ({28'd0, n} <= NMAX);
        last_col      = ({1'b0, col_q} == n_q - 4'd1);
        last_row      = ({1'b0, row_q} == n_q - 4'd1);
        row_base      = {3'b000, row_q} * {2'b00, n_q};
        next_row_base = ({3'b000, row_q} + 6'd1) * {2'b00, n_q};
    end

    // Operands are forced to zero outside data cycles so the MAC holds its sum.
    always_comb begin
        mac_a   = dvalid_q ? m_data : '0;
        mac_b   = dvalid_q ? x_data : '0;
        mac_new = dvalid_q & first_q;
        y_data  = y_we_q ? mac_p : '0;
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign m_addr = m_addr_q;
    assign x_addr = x_addr_q;
    assign y_we   = y_we_q;
    assign y_addr = y_addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            n_q      <= 4'd0;
            row_q    <= 3'd0;
            col_q    <= 3'd0;
            drain_q  <= '0;
            dvalid_q <= 1'b0;
            first_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            m_addr_q <= 6'd0;
            x_addr_q <= 3'd0;
            y_we_q   <= 1'b0;
            y_addr_q <= 3'd0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            y_we_q   <= 1'b0;
            // Read data returns one cycle after each address issued in StStream.
            dvalid_q <= (state_q == StStream);
            first_q  <= (state_q == StStream) && (col_q == 3'd0);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (n_legal) begin
                            state_q  <= StStream;
                            n_q      <= n;
                            row_q    <= 3'd0;
                            col_q    <= 3'd0;
                            busy_q   <= 1'b1;
                            m_addr_q <= 6'd0;
                            x_addr_q <= 3'd0;
                        end else begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                StStream: begin
                    if (last_col) begin
                        col_q    <= 3'd0;
                        drain_q  <= '0;
                        m_addr_q <= 6'd0;
                        x_addr_q <= 3'd0;
                        if (LAT == 0) begin
                            state_q  <= StWrite;
                            y_we_q   <= 1'b1;
                            y_addr_q <= row_q;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else begin
                        col_q    <= col_q + 3'd1;
                        m_addr_q <= row_base + {3'b000, col_q} + 6'd1;
                        x_addr_q <= col_q + 3'd1;
                    end
                end
                StDrain: begin
                    if (drain_q == CW'(LAT - 1)) begin
                        state_q  <= StWrite;
                        y_we_q   <= 1'b1;
                        y_addr_q <= row_q;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                StWrite: begin
                    y_addr_q <= 3'd0;
                    if (last_row) begin
                        state_q <= StIdle;
                        row_q   <= 3'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= StStream;
                        row_q    <= row_q + 3'd1;
                        col_q    <= 3'd0;
                        m_addr_q <= next_row_base;
                        x_addr_q <= 3'd0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq with a Q8.24 MAC and synchronous-read RAM models.
module tb_mac_seq;

    localparam int unsigned DW   = 32;
    localparam int unsigned NMAX = 8;
    localparam int unsigned LAT  = 1;
    localparam int          LATI = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    n = 4'd0;
    logic          busy, done, err, mac_new, y_we;
    logic [5:0]    m_addr;
    logic [2:0]    x_addr, y_addr;
    logic [DW-1:0] m_data, x_data, mac_a, mac_b, mac_p, y_data;

    always #5 clk = ~clk;

    mac_seq #(.DW(DW), .NMAX(NMAX), .LAT(LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .m_addr (m_addr),
        .x_addr (x_addr),
        .m_data (m_data),
        .x_data (x_data),
        .mac_new(mac_new),
        .mac_a  (mac_a),
        .mac_b  (mac_b),
        .mac_p  (mac_p),
        .y_we   (y_we),
        .y_addr (y_addr),
        .y_data (y_data)
    );

    logic [31:0] m_mem [64];
    logic [31:0] x_mem [8];

    always @(posedge clk) begin
        m_data <= m_mem[m_addr];
        x_data <= x_mem[x_addr];
    end

    function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return 32'(p >>> 24);
    endfunction

    // Q8.24 MAC, one cycle of latency
    logic [31:0] acc;
    always @(posedge clk) begin
        if (!rst_n) acc <= '0;
        else if (mac_new) acc <= q_mul(mac_a, mac_b);
        else acc <= acc + q_mul(mac_a, mac_b);
    end
    assign mac_p = acc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int row; logic [31:0] data; int at;} wr_t;
    typedef struct {logic err; int at;} dn_t;
    wr_t wr_q[$];
    dn_t dn_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or done
    always @(negedge clk) begin
        wr_t e;
        dn_t d;
        if (y_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_y_we: got y_addr=%0d y_data=%h at cycle %0d, required none",
                         y_addr, y_data, cyc);
            end else begin
                e = wr_q.pop_front();
                chk("y_addr", 64'(y_addr), 64'(e.row));
                chk("y_data", 64'(y_data), 64'(e.data));
                chk("y_we_cycle", 64'(cyc), 64'(e.at));
            end
        end
        if (done === 1'b1) begin
            if (dn_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: got done err=%0b at cycle %0d, required none", err, cyc);
            end else begin
                d = dn_q.pop_front();
                chk("done_err", 64'(err), 64'(d.err));
                chk("done_cycle", 64'(cyc), 64'(d.at));
            end
        end
        chk("err_only_with_done", 64'(err & ~done), 64'd0);
        if (busy === 1'b0) chk("idle_mac_quiet", {31'd0, mac_new, mac_a | mac_b}, 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int nn, output int s);
        start = 1'b1;
        n = 4'(nn);
        s = cyc;
    endtask

    task automatic release_start();
        step();
        start = 1'b0;
        n = 4'($urandom);
    endtask

    // Reference: y = M*x in Q8.24, modulo 2^32
    task automatic push_model(input int nn, input int s);
        logic [31:0] sum;
        if (nn == 0 || nn > int'(NMAX)) begin
            dn_q.push_back('{1'b1, s + 1});
        end else begin
            for (int r = 0; r < nn; r++) begin
                sum = '0;
                for (int c = 0; c < nn; c++) sum = sum + q_mul(m_mem[r * nn + c], x_mem[c]);
                wr_q.push_back('{r, sum, s + (r + 1) * (nn + LATI + 1)});
            end
            dn_q.push_back('{1'b0, s + nn * (nn + LATI + 1) + 1});
        end
    endtask

    task automatic wait_empty(input int limit, input string nm);
        int k = 0;
        while ((wr_q.size() != 0 || dn_q.size() != 0) && k < limit) begin
            step();
            k++;
        end
        chk(nm, 64'(wr_q.size() + dn_q.size()), 64'd0);
        wr_q.delete();
        dn_q.delete();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_flags"}, {59'd0, busy, done, err, y_we, mac_new}, 64'd0);
        chk({nm, "_addrs"}, {52'd0, m_addr, x_addr, y_addr}, 64'd0);
        chk({nm, "_y_data"}, 64'(y_data), 64'd0);
        chk({nm, "_mac_a"}, 64'(mac_a), 64'd0);
        chk({nm, "_mac_b"}, 64'(mac_b), 64'd0);
    endtask

    task automatic run_identity2(input string nm);
        int s;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_mem[0] = 32'h0100_0000;
        m_mem[3] = 32'h0100_0000;
        x_mem[0] = 32'h0300_0000;
        x_mem[1] = 32'h0500_0000;
        issue(2, s);
        wr_q.push_back('{0, 32'h0300_0000, s + 4});
        wr_q.push_back('{1, 32'h0500_0000, s + 8});
        dn_q.push_back('{1'b0, s + 9});
        release_start();
        wait_empty(40, nm);
    endtask

    task automatic run_illegal(input int nn, input string nm);
        int s;
        issue(nn, s);
        dn_q.push_back('{1'b1, s + 1});
        release_start();
        for (int k = 0; k < 3; k++) begin
            chk({nm, "_busy"}, 64'(busy), 64'd0);
            chk({nm, "_addr"}, {55'd0, m_addr, x_addr}, 64'd0);
            step();
        end
        wait_empty(10, nm);
    endtask

    initial begin
        int s, d, nn;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        for (int i = 0; i < 8; i++) x_mem[i] = '0;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        run_identity2("identity_n2");

        m_mem[0] = 32'hFC00_0000;
        x_mem[0] = 32'h0700_0000;
        issue(1, s);
        wr_q.push_back('{0, 32'hE400_0000, s + 3});
        dn_q.push_back('{1'b0, s + 4});
        release_start();
        wait_empty(20, "negative_n1");

        run_illegal(0, "illegal_n0");
        run_illegal(9, "illegal_n9");

        // Full size run with a start pulse (and n change) mid-computation
        for (int i = 0; i < 64; i++) m_mem[i] = 32'h0100_0000;
        for (int i = 0; i < 8; i++) x_mem[i] = 32'h0100_0000;
        issue(8, s);
        for (int r = 0; r < 8; r++) wr_q.push_back('{r, 32'h0800_0000, s + 10 * (r + 1)});
        dn_q.push_back('{1'b0, s + 81});
        release_start();
        while (cyc < s + 30) step();
        start = 1'b1;
        n = 4'd2;
        step();
        start = 1'b0;
        wait_empty(120, "full_n8");

        // Reset during an n=3 run: only the row-0 write at cycle 5 survives
        for (int i = 0; i < 64; i++) m_mem[i] = $urandom;
        for (int i = 0; i < 8; i++) x_mem[i] = $urandom;
        issue(3, s);
        push_model(3, s);
        while (wr_q.size() > 1) void'(wr_q.pop_back());
        dn_q.delete();
        release_start();
        while (cyc < s + 5) step();
        rst_n = 1'b0;
        step();
        chk_all_zero("midreset");
        rst_n = 1'b1;
        repeat (20) step();
        wait_empty(1, "midreset_drain");
        run_identity2("identity_after_reset");

        // Random chain, each start issued in the previous run's done cycle
        for (int i = 0; i < 64; i++) m_mem[i] = $urandom;
        for (int i = 0; i < 8; i++) x_mem[i] = $urandom;
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 4) == 0) nn = (t % 2 == 0) ? 0 : $urandom_range(9, 15);
            else nn = $urandom_range(1, 8);
            issue(nn, s);
            push_model(nn, s);
            d = dn_q[dn_q.size() - 1].at;
            release_start();
            while (cyc < d) step();
            for (int i = 0; i < 64; i++) m_mem[i] = $urandom;
            for (int i = 0; i < 8; i++) x_mem[i] = $urandom;
        end
        wait_empty(200, "random_chain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
